// File: rtl/arm_pkg.sv
// Shared encodings for the multi-cycle ARM controller: FSM states, mux selects and
// instruction-field constants.
package arm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        EXECMUL  = 4'd10
    } state_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_MUL    = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] MUL_INSTR74 = 4'b1001;

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter with zero flag; holds at zero. Synchronous active-high reset.
module cycle_counter #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/main_fsm.sv
// Multi-cycle main controller FSM sharing one ALU and one memory port.
// Define MAIN_FSM_MUL_EN to add the EXECMUL state and multi-cycle multiplier sequencing.
module main_fsm
    import arm_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] instr74,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       mul_start,
    output logic [3:0] state
);

    if (MUL_CYCLES < 1) begin : g_bad_cfg
        $error("MUL_CYCLES must be at least 1");
    end

    state_t state_q, state_d;

`ifdef MAIN_FSM_MUL_EN
    localparam int unsigned CntW = $clog2(MUL_CYCLES) + 1;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);

    logic [CntW-1:0] cnt;
    logic            cnt_zero;
    logic            mul_flag_q;
    logic            is_mul;

    assign is_mul = (funct[5:1] == 5'b00000) && (instr74 == MUL_INSTR74);

    cycle_counter #(
        .Width(CntW)
    ) u_cycle_counter (
        .clk       (clk),
        .reset     (reset),
        .load      ((state_q == DECODE) && (state_d == EXECMUL)),
        .load_value(MulLoad),
        .en        (state_q == EXECMUL),
        .count     (cnt),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_flag_q <= 1'b0;
        end else if ((state_q == EXECMUL) && cnt_zero) begin
            mul_flag_q <= 1'b1;
        end else if (state_q == ALUWB) begin
            mul_flag_q <= 1'b0;
        end
    end

    // Counter still holds its load value only in the first EXECMUL cycle.
    assign mul_start = (state_q == EXECMUL) && (cnt == MulLoad);
`else
    logic unused_mul_fields;
    assign unused_mul_fields = ^{instr74, funct[4:1]};
    assign mul_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        alu_op     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                case (op)
                    OP_MEM: state_d = MEMADR;
                    OP_BR:  state_d = BRANCH;
                    OP_DP: begin
                        if (funct[5]) begin
                            state_d = EXECI;
                        end else begin
`ifdef MAIN_FSM_MUL_EN
                            state_d = is_mul ? EXECMUL : EXECR;
`else
                            state_d = EXECR;
`endif
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b = SRCB_IMM;
                state_d   = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                state_d = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_b = SRCB_REG;
                alu_op    = 1'b1;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_w = 1'b1;
`ifdef MAIN_FSM_MUL_EN
                result_src = mul_flag_q ? RES_MUL : RES_ALUOUT;
`endif
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                branch     = 1'b1;
            end
`ifdef MAIN_FSM_MUL_EN
            EXECMUL: begin
                state_d = cnt_zero ? ALUWB : EXECMUL;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: state sequences, strobes, stalls and resets.
// Multiply checks follow whether MAIN_FSM_MUL_EN is defined.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] instr74;
    logic       mem_ready;
    logic       ir_write, next_pc, adr_src, alu_src_a, alu_op;
    logic       reg_w, mem_w, branch, mul_start;
    logic [1:0] alu_src_b, result_src;
    logic [3:0] state;

    int num_checks = 0;
    int num_pass   = 0;

    always #5 clk = ~clk;

    main_fsm #(
        .MUL_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .instr74   (instr74),
        .mem_ready (mem_ready),
        .ir_write  (ir_write),
        .next_pc   (next_pc),
        .adr_src   (adr_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .result_src(result_src),
        .alu_op    (alu_op),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .branch    (branch),
        .mul_start (mul_start),
        .state     (state)
    );

    task automatic check(input string tag, input int got, input int exp);
        num_checks++;
        if (got == exp) begin
            num_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_state(input string tag, input int exp);
        step();
        check(tag, int'(state), exp);
    endtask

    task automatic set_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] i74);
        op      = o;
        funct   = f;
        instr74 = i74;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        set_instr(2'b11, 6'd0, 4'd0);
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_state", int'(state), 0);
        check("rst_ir_write", int'(ir_write), 1);
        check("rst_next_pc", int'(next_pc), 1);
        check("rst_alu_src_b", int'(alu_src_b), 2);
        check("rst_strobes", int'({reg_w, mem_w, branch, mul_start}), 0);

        // Data-processing register form: 0,1,6,8,0
        set_instr(2'b00, 6'b001000, 4'b0000);
        step_state("dp_decode", 1);
        check("dp_decode_no_irw", int'(ir_write), 0);
        step_state("dp_execr", 6);
        check("dp_execr_alu_op", int'(alu_op), 1);
        step_state("dp_aluwb", 8);
        check("dp_aluwb_reg_w", int'(reg_w), 1);
        check("dp_aluwb_result_src", int'(result_src), 0);
        step_state("dp_fetch", 0);

        // Immediate form goes through EXECI
        set_instr(2'b00, 6'b101000, 4'b0000);
        step_state("dpi_decode", 1);
        step_state("dpi_execi", 7);
        check("dpi_execi_src_b", int'(alu_src_b), 1);
        step_state("dpi_aluwb", 8);
        step_state("dpi_fetch", 0);

        // LDR with two stall cycles in MEMREAD: 0,1,2,3,3,3,4,0
        set_instr(2'b01, 6'b011001, 4'b0000);
        step_state("ldr_decode", 1);
        step_state("ldr_memadr", 2);
        check("ldr_memadr_src_b", int'(alu_src_b), 1);
        step_state("ldr_memread", 3);
        mem_ready = 1'b0;
        check("ldr_memread_adr_src", int'(adr_src), 1);
        step_state("ldr_stall1", 3);
        check("ldr_stall_strobes", int'({ir_write, next_pc, reg_w, mem_w, branch}), 0);
        step_state("ldr_stall2", 3);
        mem_ready = 1'b1;
        step_state("ldr_memwb", 4);
        check("ldr_memwb_result_src", int'(result_src), 1);
        check("ldr_memwb_reg_w", int'(reg_w), 1);
        step_state("ldr_fetch", 0);

        // STR with one stall in MEMWRITE
        set_instr(2'b01, 6'b011000, 4'b0000);
        step_state("str_decode", 1);
        check("str_decode_mem_w", int'(mem_w), 0);
        step_state("str_memadr", 2);
        check("str_memadr_mem_w", int'(mem_w), 0);
        step_state("str_memwrite", 5);
        mem_ready = 1'b0;
        check("str_memwrite_mem_w", int'(mem_w), 1);
        step_state("str_stall", 5);
        check("str_stall_mem_w", int'(mem_w), 1);
        check("str_stall_reg_w", int'(reg_w), 0);
        mem_ready = 1'b1;
        step_state("str_fetch", 0);
        check("str_fetch_mem_w", int'(mem_w), 0);

        // Branch: 3 cycles
        set_instr(2'b10, 6'b000000, 4'b0000);
        step_state("br_decode", 1);
        step_state("br_branch", 9);
        check("br_branch_strobe", int'(branch), 1);
        check("br_src_b", int'(alu_src_b), 1);
        check("br_result_src", int'(result_src), 2);
        step_state("br_fetch", 0);

        // FETCH stall holds and suppresses strobes
        mem_ready = 1'b0;
        #1;
        check("fetch_stall_ir_write", int'(ir_write), 0);
        check("fetch_stall_next_pc", int'(next_pc), 0);
        step_state("fetch_stall_hold", 0);
        mem_ready = 1'b1;
        #1;
        check("fetch_ready_ir_write", int'(ir_write), 1);

        // op=11 falls back to FETCH
        set_instr(2'b11, 6'b000000, 4'b0000);
        step_state("op11_decode", 1);
        step_state("op11_fetch", 0);

        // Reset mid-stall in MEMREAD aborts without writeback
        set_instr(2'b01, 6'b011001, 4'b0000);
        step_state("rstld_decode", 1);
        step_state("rstld_memadr", 2);
        step_state("rstld_memread", 3);
        mem_ready = 1'b0;
        reset     = 1'b1;
        step_state("rstld_state", 0);
        check("rstld_reg_w", int'(reg_w), 0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        step_state("rstld_resume", 1);
        set_instr(2'b11, 6'b000000, 4'b0000);
        step_state("rstld_fetch", 0);

        // Multiply encoding
        set_instr(2'b00, 6'b000000, 4'b1001);
`ifdef MAIN_FSM_MUL_EN
        step_state("mul_decode", 1);
        step_state("mul_exec1", 10);
        check("mul_start_first", int'(mul_start), 1);
        step_state("mul_exec2", 10);
        check("mul_start_second", int'(mul_start), 0);
        step_state("mul_exec3", 10);
        step_state("mul_exec4", 10);
        check("mul_start_last", int'(mul_start), 0);
        step_state("mul_aluwb", 8);
        check("mul_result_src", int'(result_src), 3);
        check("mul_reg_w", int'(reg_w), 1);
        step_state("mul_fetch", 0);

        // Next plain DP must not see a stale mul flag
        set_instr(2'b00, 6'b001000, 4'b0000);
        step_state("mdp_decode", 1);
        step_state("mdp_execr", 6);
        step_state("mdp_aluwb", 8);
        check("mdp_result_src", int'(result_src), 0);
        step_state("mdp_fetch", 0);

        // Reset in the second EXECMUL cycle
        set_instr(2'b00, 6'b000000, 4'b1001);
        step_state("rmul_decode", 1);
        step_state("rmul_exec1", 10);
        step_state("rmul_exec2", 10);
        reset = 1'b1;
        step_state("rmul_state", 0);
        check("rmul_reg_w", int'(reg_w), 0);
        reset = 1'b0;
        step_state("rmul2_decode", 1);
        step_state("rmul2_exec1", 10);
        check("rmul2_mul_start", int'(mul_start), 1);
        step_state("rmul2_exec2", 10);
        step_state("rmul2_exec3", 10);
        step_state("rmul2_exec4", 10);
        step_state("rmul2_aluwb", 8);
        check("rmul2_result_src", int'(result_src), 3);
        step_state("rmul2_fetch", 0);
`else
        step_state("mul_decode", 1);
        step_state("mul_execr", 6);
        check("mul_start_off", int'(mul_start), 0);
        step_state("mul_aluwb", 8);
        check("mul_result_src", int'(result_src), 0);
        step_state("mul_fetch", 0);
`endif

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle sequencing FSM for the ARM core; it replaces single-cycle main decoding with a state-based schedule that time-shares one ALU and one unified memory port across fetch, address, execute and writeback. It sits inside the controller, beside the ALU decoder and conditional logic, and drives raw (ungated) control strobes. Conditional logic gates `reg_w`, `mem_w` and `branch` with `cond_ex` downstream. It stalls on a memory-ready handshake and, optionally, sequences a multi-cycle multiplier.

## Interface
- `MUL_CYCLES`, default 4: multiplier latency in cycles. Legal range is ≥1; only used with `MUL_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 2: instr[27:26].
- `funct` in 6: instr[25:20].
- `instr74` in 4: instr[7:4].
- `mem_ready` in 1: memory access completes this cycle (level, sampled at edge).
- `ir_write` out 1: load instruction register.
- `next_pc` out 1: PC update strobe.
- `adr_src` out 1: 0=PC, 1=ALUOut.
- `alu_src_a` out 1: 0=RegA, 1=PC.
- `alu_src_b` out 2: 00=RegB, 01=ExtImm, 10=const 4.
- `result_src` out 2: 00=ALUOut, 01=Data, 10=ALUResult, 11=MulOut.
- `alu_op` out 1: 1 means ALU decoder uses `funct`; 0 forces ADD.
- `reg_w`, `mem_w`, `branch` out 1 each: raw strobes.
- `mul_start` out 1: one-cycle multiplier launch.
- `state` out 4: current state, for debug and bench.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, EXECMUL.
- FETCH
  - Outputs: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, alu_op=0.
  - `ir_write` and `next_pc` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when it is 1.
- DECODE
  - Outputs: alu_src_a=1, alu_src_b=10, result_src=10 (computes PC+8).
  - Next state by `op`:
    - op=01 → MEMADR.
    - op=10 → BRANCH.
    - op=00 with funct[5]=1 → EXECI.
    - op=00 with funct[5]=0 → EXECR, or EXECMUL when it is a multiply: `MUL_EN`, funct[5:1]=00000 and instr74=1001.
    - op=11 → FETCH, no strobes.
- MEMADR: alu_src_b=01, alu_op=0. Goes to MEMREAD if funct[0]=1, else MEMWRITE.
- MEMREAD: adr_src=1. Waits for `mem_ready`, then MEMWB.
- MEMWB: result_src=01, reg_w=1, then FETCH.
- MEMWRITE: adr_src=1, `mem_w`=1 every cycle in this state. Waits for `mem_ready`, then FETCH.
- EXECR: alu_src_b=00, alu_op=1, then ALUWB.
- EXECI: alu_src_b=01, alu_op=1, then ALUWB.
- ALUWB: reg_w=1, result_src=11 if the mul flag is set, else 00. Clears the flag, then FETCH.
- BRANCH: alu_src_b=01, result_src=10, branch=1, alu_op=0, then FETCH.
- EXECMUL
  - `mul_start`=1 in the first cycle only. Down-counter is loaded with MUL_CYCLES-1 on entry.
  - At count 0, sets the mul flag and moves to ALUWB.
- Defaults: any output not listed for a state is 0.

## Timing
- Moore FSM: the state is registered and all outputs decode from it, except the FETCH strobes, which also depend on `mem_ready`.
- With `mem_ready` held at 1, cycles per instruction are:
  - BRANCH: 3.
  - Data-processing: 4.
  - STR: 4.
  - LDR: 5.
  - MUL: 3+MUL_CYCLES.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No strobe other than `mem_w` (in MEMWRITE) fires while stalled.
- Reset:
  - At the next edge: state=FETCH, counter=0, mul flag=0.
  - Outputs are then FETCH values, with `ir_write`=`next_pc`=`mem_ready`, all other strobes 0, state=0000.
  - A reset mid-instruction (including mid-EXECMUL or mid-stall) aborts it with no writeback.
- Illegal state encodings go to FETCH at the next edge.
- Counter width is $clog2(MUL_CYCLES)+1. With MUL_CYCLES=1, EXECMUL lasts one cycle.

## Configuration
- `MAIN_FSM_MUL_EN` defined:
  - EXECMUL, the counter, the mul flag and `mul_start` are implemented.
  - The multiply pattern is routed as described in Operation.
- `MAIN_FSM_MUL_EN` undefined:
  - None of the multiply logic exists.
  - `mul_start` is tied to 0 and `result_src` never takes 11.
  - Multiply encodings go through EXECR, 4 cycles.

## Structure
- Shared package `arm_pkg` holds:
  - `state_t` enum with fixed encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, EXECMUL=10.
  - Encodings for `alu_src_b` and `result_src`.
  - Constants OP_DP=00, OP_MEM=01, OP_BR=10, MUL_INSTR74=1001.
- One sub-module, `cycle_counter`: loadable down-counter with a zero flag, parameterised width. It is instantiated only under `MAIN_FSM_MUL_EN`.

## Test plan
- After reset with mem_ready=1: state=0, ir_write=1, next_pc=1, alu_src_b=10, and reg_w=mem_w=branch=0.
- Data-processing register form (op=00, funct=001000): state sequence 0,1,6,8,0. In state 8, reg_w=1 and result_src=00; in state 6, alu_op=1.
- LDR (op=01, funct=011001) with mem_ready low for 2 cycles in MEMREAD: sequence 0,1,2,3,3,3,4,0. MEMWB has result_src=01 and reg_w=1.
- STR (op=01, funct=011000): mem_w=1 only in state 5. Branch (op=10): state 9 with branch=1, alu_src_b=01, 3 cycles total.
- With MAIN_FSM_MUL_EN and MUL_CYCLES=4, funct=000000 and instr74=1001: sequence 1, then 10 for 4 cycles, then 8. mul_start is high in the first cycle of state 10 only; ALUWB has result_src=11.
- Reset asserted in the 2nd cycle of EXECMUL: state=0 next cycle, no reg_w. The next multiply again spends 4 cycles in state 10.
